// File: rtl/demux16_reg_pkg.sv
// Shared types and constants for the registered 1-to-16 demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;
    localparam int OCC_W  = 5;

    typedef logic [SEL_W-1:0]  ch_sel_t;
    typedef logic [NUM_CH-1:0] ch_mask_t;

    function automatic logic [OCC_W-1:0] popcount(ch_mask_t m);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + OCC_W'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/demux16_reg_if.sv
// Producer stream plus 16 consumer handshakes for demux16_reg.
interface demux16_reg_if #(
    parameter int width = 32
);
    import demux_pkg::*;

    logic                         in_valid;
    ch_sel_t                      in_sel;
    logic [width-1:0]             in_data;
    logic                         in_ready;
    ch_mask_t                     out_valid;
    ch_mask_t                     out_ready;
    logic [NUM_CH-1:0][width-1:0] out_data;
    logic [OCC_W-1:0]             occupancy;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/demux16_reg_slot.sv
// One-entry holding register; a load wins over a drain in the same cycle.
module demux_slot #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [width-1:0] load_data,
    input  logic             drain,
    output logic             full,
    output logic [width-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux16_reg.sv
// Registered 1-to-16 demux: one input stream steered into 16 one-entry
// slots, each drained by its own consumer handshake.
module demux16_reg
    import demux_pkg::*;
#(
    parameter int width = 32
) (
    input logic           clk,
    input logic           rst,
    demux16_reg_if.slave  bus
);

    ch_mask_t                     full;
    ch_mask_t                     load;
    ch_mask_t                     drain;
    logic [NUM_CH-1:0][width-1:0] data_q;
    logic [OCC_W-1:0]             occ;
    logic [OCC_W-1:0]             occ_next;
    logic                         sel_known;
    logic                         ready;
    logic                         accept;

    assign sel_known = !$isunknown(bus.in_sel);
    assign ready     = !rst && sel_known &&
                       (!full[bus.in_sel] || bus.out_ready[bus.in_sel]);
    assign accept    = bus.in_valid && ready;
    assign drain     = full & bus.out_ready;

    always_comb begin
        load = '0;
        if (accept) begin
            load = ch_mask_t'(1) << bus.in_sel;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(.width(width)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .load_data (bus.in_data),
            .drain     (drain[i]),
            .full      (full[i]),
            .data      (data_q[i])
        );
    end

    // A refilled slot stays full, so only drains without a load leave.
    always_comb begin
        occ_next = occ - popcount(drain & ~load);
        if (accept && !full[bus.in_sel]) begin
            occ_next = occ_next + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            occ <= occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.in_valid && !sel_known) begin
            $display("Unknown_16demux_sel");
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = full;
    assign bus.out_data  = data_q;
    assign bus.occupancy = occ;

endmodule

// File: tb/tb_demux16_reg.sv
// Directed bench for demux16_reg with a per-channel scoreboard
// checked by an independent drain monitor.
module tb_demux16_reg;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] q [16][$];

    demux16_reg_if #(.width(32)) bus ();

    demux16_reg #(.width(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drains are decided by inputs held since the last rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("drain_unexpected_ch%0d", i), 1, 0);
                    end else begin
                        chk($sformatf("drain_data_ch%0d", i),
                            64'(bus.out_data[i]), 64'(q[i].pop_front()));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] sel, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
        @(negedge clk);
        chk($sformatf("send_ready_sel%0d", sel), 64'(bus.in_ready), 1);
        if (bus.in_ready) q[sel].push_back(d);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int left;
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_sel     = 4'd0;
        bus.in_data    = 32'hDEAD;
        bus.out_ready  = '0;

        #3;
        chk("rst_valid", 64'(bus.out_valid), 0);
        chk("rst_occ", 64'(bus.occupancy), 0);
        chk("rst_ready", 64'(bus.in_ready), 0);
        chk("rst_data_zero", 64'(bus.out_data == '0), 1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // Fill every channel with out_ready low.
        for (int s = 0; s < 16; s++) send(4'(s), 32'hA0 + 32'(s));
        @(negedge clk);
        chk("fill_occ", 64'(bus.occupancy), 16);
        chk("fill_valid", 64'(bus.out_valid), 64'hFFFF);
        for (int k = 0; k < 16; k++)
            chk($sformatf("fill_data%0d", k), 64'(bus.out_data[k]),
                64'hA0 + 64'(k));
        step();
        bus.out_ready = '1;
        step();
        bus.out_ready = '0;
        @(negedge clk);
        chk("drained_occ", 64'(bus.occupancy), 0);
        step();

        // Blocked slot, then same-cycle drain and refill.
        send(4'd5, 32'h11);
        bus.in_valid = 1'b1;
        bus.in_sel   = 4'd5;
        bus.in_data  = 32'h22;
        @(negedge clk);
        chk("blocked_ready", 64'(bus.in_ready), 0);
        chk("blocked_data", 64'(bus.out_data[5]), 64'h11);
        step();
        bus.out_ready = 16'h0020;
        @(negedge clk);
        chk("refill_ready", 64'(bus.in_ready), 1);
        if (bus.in_ready) q[5].push_back(32'h22);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        @(negedge clk);
        chk("refill_valid", 64'(bus.out_valid[5]), 1);
        chk("refill_data", 64'(bus.out_data[5]), 64'h22);
        chk("refill_occ", 64'(bus.occupancy), 1);
        step();
        bus.out_ready = 16'h0020;
        step();
        bus.out_ready = '0;

        // Two drains plus an accept elsewhere in one cycle.
        send(4'd2, 32'h92);
        send(4'd9, 32'h99);
        bus.out_ready = 16'h0204;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd4;
        bus.in_data   = 32'h44;
        @(negedge clk);
        chk("multi_ready", 64'(bus.in_ready), 1);
        chk("multi_occ_before", 64'(bus.occupancy), 2);
        if (bus.in_ready) q[4].push_back(32'h44);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        @(negedge clk);
        chk("multi_occ_after", 64'(bus.occupancy), 1);
        chk("multi_valid", 64'(bus.out_valid), 64'h0010);
        step();

        // Asynchronous reset with seven words held.
        send(4'd0, 32'h100);
        send(4'd1, 32'h101);
        send(4'd3, 32'h103);
        send(4'd6, 32'h106);
        send(4'd7, 32'h107);
        send(4'd8, 32'h108);
        chk("pre_rst_occ", 64'(bus.occupancy), 7);
        #2;
        bus.in_valid = 1'b1;
        bus.in_sel   = 4'd10;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 0);
        chk("arst_occ", 64'(bus.occupancy), 0);
        chk("arst_data_zero", 64'(bus.out_data == '0), 1);
        chk("arst_ready", 64'(bus.in_ready), 0);
        for (int i = 0; i < 16; i++) q[i].delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // Unknown select with every slot full must not load anything.
        for (int s = 0; s < 16; s++) send(4'(s), 32'hC0 + 32'(s));
        bus.in_valid = 1'b1;
        bus.in_sel   = 'x;
        bus.in_data  = 32'hBAD;
        @(negedge clk);
        chk("xsel_ready", 64'(bus.in_ready), 0);
        step();
        bus.in_valid = 1'b0;
        bus.in_sel   = 4'd0;
        @(negedge clk);
        chk("xsel_occ", 64'(bus.occupancy), 16);
        chk("xsel_data0", 64'(bus.out_data[0]), 64'hC0);
        step();

        bus.out_ready = '1;
        step();
        bus.out_ready = '0;
        @(negedge clk);
        chk("final_occ", 64'(bus.occupancy), 0);
        left = 0;
        for (int i = 0; i < 16; i++) left += q[i].size();
        chk("scoreboard_empty", 64'(left), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
